// File: rtl/jtkiwi_vram_slots.sv
// jtkiwi_vram_slots
//
// Time-slot sharer that lets up to eight graphics clients read one synchronous-read
// RAM port. A free-running slot counter advances on every cen-qualified clock edge.
// Slot s belongs to channel s. Free slots (s >= CH), and slots whose owner is idle,
// can optionally be handed to the lowest-index pending channel. Each grant is
// acknowledged with a one-clock ack pulse. A tag then travels down a return pipeline,
// so the read data comes back on dout with a matching dvalid pulse.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   cen       slot advance enable; one arbitration per qualified edge
//   req       per-channel level request
//   addr      packed channel addresses, channel c at addr[c*AW +: AW]
//   ack       one-clock one-hot pulse: address of that channel was accepted
//   dvalid    one-clock one-hot pulse: dout holds that channel's data
//   dout      registered read data, held between returns
//   ram_addr  registered RAM read address
//   ram_q     RAM read data, valid RAM_LAT clocks after ram_addr changes
//   slot      slot that the next cen edge evaluates
//   busy      any read still in the return pipeline
module jtkiwi_vram_slots #(
    parameter int unsigned CH      = 4,
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 16,
    parameter int unsigned SLOTW   = 2,
    parameter int unsigned RECLAIM = 1,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [CH-1:0]    req,
    input  logic [CH*AW-1:0] addr,
    output logic [CH-1:0]    ack,
    output logic [CH-1:0]    dvalid,
    output logic [DW-1:0]    dout,
    output logic [AW-1:0]    ram_addr,
    input  logic [DW-1:0]    ram_q,
    output logic [SLOTW-1:0] slot,
    output logic             busy
);

    // Stage 0 is loaded on the grant edge. The last stage lines up with ram_q
    // becoming valid for that grant.
    localparam int unsigned DEPTH = RAM_LAT + 1;

    logic [SLOTW-1:0] slot_q;
    logic [AW-1:0]    ram_addr_q;
    logic [CH-1:0]    tag_q [DEPTH];
    logic [CH-1:0]    dvalid_q;
    logic [DW-1:0]    dout_q;

    logic [CH-1:0]    owner_hit;
    logic [CH-1:0]    lowest_req;
    logic [CH-1:0]    grant;
    logic [AW-1:0]    grant_addr;

    // The owner of the current slot is requesting. This is empty on free slots.
    always_comb begin
        owner_hit = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (slot_q == SLOTW'(c)) begin
                owner_hit[c] = req[c];
            end
        end
    end

    // Isolate the lowest set request bit.
    assign lowest_req = req & (~req + CH'(1));

    // The owner always wins its own slot. Reclaim only fills slots the owner leaves idle.
    always_comb begin
        grant = '0;
        if (cen) begin
            if (|owner_hit) begin
                grant = owner_hit;
            end else if (RECLAIM != 0) begin
                grant = lowest_req;
            end
        end
    end

    always_comb begin
        grant_addr = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (grant[c]) begin
                grant_addr = addr[c*AW +: AW];
            end
        end
    end

    // The tags are kept as one-hot channel vectors. A zero vector is an invalid tag.
    // The pipeline advances every clock, so returns drain even while cen is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            ram_addr_q <= '0;
            dvalid_q   <= '0;
            dout_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (cen) begin
                slot_q <= slot_q + SLOTW'(1);
            end
            if (|grant) begin
                ram_addr_q <= grant_addr;
            end
            tag_q[0] <= grant;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            dvalid_q <= tag_q[DEPTH-1];
            if (|tag_q[DEPTH-1]) begin
                dout_q <= ram_q;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy = busy | (|tag_q[i]);
        end
    end

    assign slot     = slot_q;
    assign ram_addr = ram_addr_q;
    assign ack      = tag_q[0];
    // While reset is asserted, a return that was already registered is not shown to clients.
    assign dvalid   = dvalid_q & ~{CH{rst}};
    assign dout     = dout_q;

endmodule

// File: tb/tb_jtkiwi_vram_slots.sv
// Bench for jtkiwi_vram_slots. It has three instances:
//   0: CH=4, RECLAIM=0, RAM_LAT=1
//   1: CH=4, RECLAIM=1, RAM_LAT=2
//   2: CH=3, RECLAIM=1, RAM_LAT=1
// A behavioural model runs next to each instance. It keeps a slot number and a queue
// of pending returns, each with a due cycle.
module tb_jtkiwi_vram_slots;

    localparam int NI = 3;
    localparam int OW = 39;

    typedef struct {
        int          due;
        int          ch;
        logic [15:0] data;
    } ret_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s  [NI];
    logic        cen_s  [NI];
    logic [3:0]  req_s  [NI];
    logic [11:0] addr_s [NI][4];

    wire [3:0]    ack_w  [NI];
    wire [3:0]    dv_w   [NI];
    wire [15:0]   dout_w [NI];
    wire [11:0]   ra_w   [NI];
    wire [1:0]    slot_w [NI];
    wire          busy_w [NI];
    wire [OW-1:0] obs_w  [NI];
    wire [OW-1:0] exp_w  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // RAM contents are a fixed scramble of the address.
    function automatic logic [15:0] word(input logic [11:0] a);
        logic [15:0] x;
        x = {4'h0, a} * 16'd40503;
        return x ^ {a[7:0], a[11:4]};
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int CHK = (k == 2) ? 3 : 4;
        localparam int RK  = (k == 0) ? 0 : 1;
        localparam int LK  = (k == 1) ? 2 : 1;

        wire  [CHK*12-1:0] addr_p;
        wire  [CHK-1:0]    ack_n;
        wire  [CHK-1:0]    dv_n;
        wire  [15:0]       ram_q;
        logic [15:0]       r1;
        logic [15:0]       r2;

        for (genvar c = 0; c < CHK; c++) begin : g_a
            assign addr_p[c*12 +: 12] = addr_s[k][c];
        end

        jtkiwi_vram_slots #(
            .CH      (CHK),
            .AW      (12),
            .DW      (16),
            .SLOTW   (2),
            .RECLAIM (RK),
            .RAM_LAT (LK)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_s[k]),
            .cen      (cen_s[k]),
            .req      (req_s[k][CHK-1:0]),
            .addr     (addr_p),
            .ack      (ack_n),
            .dvalid   (dv_n),
            .dout     (dout_w[k]),
            .ram_addr (ra_w[k]),
            .ram_q    (ram_q),
            .slot     (slot_w[k]),
            .busy     (busy_w[k])
        );

        assign ack_w[k] = 4'(ack_n);
        assign dv_w[k]  = 4'(dv_n);

        // Synchronous-read RAM with LK cycles of latency.
        always @(posedge clk) begin
            r1 <= word(ra_w[k]);
            r2 <= r1;
        end
        assign ram_q = (LK == 2) ? r2 : r1;

        // Reference model.
        ret_t        q[$];
        int          m_cyc  = 0;
        logic [1:0]  m_slot = '0;
        logic [3:0]  m_ack  = '0;
        logic [3:0]  m_dv   = '0;
        logic [15:0] m_dout = '0;
        logic [11:0] m_ra   = '0;
        logic        m_busy = 1'b0;

        always @(posedge clk) begin : model
            int   g;
            ret_t r;
            m_cyc <= m_cyc + 1;
            if (rst_s[k]) begin
                q.delete();
                m_slot <= '0;
                m_ack  <= '0;
                m_dv   <= '0;
                m_dout <= '0;
                m_ra   <= '0;
                m_busy <= 1'b0;
            end else begin
                m_dv <= '0;
                if (q.size() != 0 && q[0].due == m_cyc) begin
                    m_dv   <= 4'(1 << q[0].ch);
                    m_dout <= q[0].data;
                    void'(q.pop_front());
                end
                g = -1;
                if (cen_s[k]) begin
                    if (int'(m_slot) < CHK && req_s[k][m_slot]) begin
                        g = int'(m_slot);
                    end else if (RK != 0) begin
                        for (int c = CHK - 1; c >= 0; c--) begin
                            if (req_s[k][c]) g = c;
                        end
                    end
                    m_slot <= m_slot + 2'd1;
                end
                m_ack <= '0;
                if (g >= 0) begin
                    m_ack  <= 4'(1 << g);
                    m_ra   <= addr_s[k][g];
                    r.due  = m_cyc + LK + 1;
                    r.ch   = g;
                    r.data = word(addr_s[k][g]);
                    q.push_back(r);
                end
                m_busy <= (q.size() != 0);
            end
        end

        assign obs_w[k] = {ack_w[k], dv_w[k], dout_w[k], ra_w[k], slot_w[k], busy_w[k]};
        assign exp_w[k] = {m_ack, m_dv, m_dout, m_ra, m_slot, m_busy};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            rst_s[k] = 1'b1;
            cen_s[k] = 1'b0;
            req_s[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (obs_w[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_state inst=%0d got=%h exp=0", k, obs_w[k]);
            end
            rst_s[k] = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int nxt = 0;
        int n_ack = 0;
        int ack_t[4] = '{-100, -100, -100, -100};
        for (int c = 0; c < 4; c++) addr_s[0][c] = 12'(12'h100 + c);
        req_s[0] = 4'hF;
        for (int t = 0; t < 52; t++) begin
            cen_s[0] = (t % 4 == 0) && (t < 48);
            tick();
            n_checks++;
            if (obs_w[0] !== exp_w[0]) begin
                n_fail++;
                $display("FAIL rr_model t=%0d got=%h exp=%h", t, obs_w[0], exp_w[0]);
            end
            if (ack_w[0] != 4'h0) begin
                n_checks++;
                if (ack_w[0] !== 4'(1 << nxt)) begin
                    n_fail++;
                    $display("FAIL rr_order t=%0d got=%b exp=%b", t, ack_w[0], 4'(1 << nxt));
                end
                ack_t[nxt] = t;
                nxt = (nxt + 1) % 4;
                n_ack++;
            end
            for (int c = 0; c < 4; c++) begin
                if (dv_w[0][c]) begin
                    n_checks++;
                    if (t - ack_t[c] != 2 || dout_w[0] !== word(12'(12'h100 + c))) begin
                        n_fail++;
                        $display("FAIL rr_return ch=%0d got lag=%0d dout=%h exp lag=2 dout=%h",
                                 c, t - ack_t[c], dout_w[0], word(12'(12'h100 + c)));
                    end
                end
            end
        end
        n_checks++;
        if (n_ack != 12) begin
            n_fail++;
            $display("FAIL rr_count got=%0d exp=12", n_ack);
        end
        req_s[0] = '0;
    endtask

    task automatic test_only_ch2();
        for (int k = 0; k < 2; k++) begin
            int         cnt = 0;
            logic [1:0] prev;
            addr_s[k][2] = 12'h2A5;
            req_s[k] = 4'b0100;
            cen_s[k] = 1'b1;
            prev = slot_w[k];
            for (int t = 0; t < 16; t++) begin
                tick();
                n_checks++;
                if (obs_w[k] !== exp_w[k]) begin
                    n_fail++;
                    $display("FAIL ch2_model inst=%0d got=%h exp=%h", k, obs_w[k], exp_w[k]);
                end
                if (ack_w[k] != 4'h0) begin
                    cnt++;
                    n_checks++;
                    if (ack_w[k] !== 4'b0100 || (k == 0 && prev !== 2'd2)) begin
                        n_fail++;
                        $display("FAIL ch2_slot inst=%0d got ack=%b slot=%0d exp ack=0100",
                                 k, ack_w[k], prev);
                    end
                end
                prev = slot_w[k];
            end
            cen_s[k] = 1'b0;
            req_s[k] = '0;
            n_checks++;
            if (cnt != ((k == 0) ? 4 : 16)) begin
                n_fail++;
                $display("FAIL ch2_count inst=%0d got=%0d exp=%0d", k, cnt, (k == 0) ? 4 : 16);
            end
            for (int t = 0; t < 4; t++) tick();
        end
    endtask

    task automatic test_free_slot();
        logic [1:0] prev;
        logic [3:0] want;
        addr_s[2][0] = 12'($urandom);
        addr_s[2][1] = 12'($urandom);
        req_s[2] = 4'b0011;
        cen_s[2] = 1'b1;
        prev = slot_w[2];
        for (int t = 0; t < 16; t++) begin
            tick();
            want = (prev == 2'd1) ? 4'b0010 : 4'b0001;
            n_checks++;
            if (ack_w[2] !== want) begin
                n_fail++;
                $display("FAIL free_slot slot=%0d got=%b exp=%b", prev, ack_w[2], want);
            end
            n_checks++;
            if (obs_w[2] !== exp_w[2]) begin
                n_fail++;
                $display("FAIL free_model got=%h exp=%h", obs_w[2], exp_w[2]);
            end
            prev = slot_w[2];
        end
        cen_s[2] = 1'b0;
        req_s[2] = '0;
        for (int t = 0; t < 4; t++) tick();
    endtask

    task automatic test_back_to_back();
        int          qt[$];
        int          qc[$];
        logic [11:0] qa[$];
        for (int c = 0; c < 4; c++) addr_s[1][c] = 12'($urandom);
        req_s[1] = 4'hF;
        for (int t = 0; t < 30; t++) begin
            cen_s[1] = (t < 24);
            tick();
            n_checks++;
            if (obs_w[1] !== exp_w[1]) begin
                n_fail++;
                $display("FAIL b2b_model t=%0d got=%h exp=%h", t, obs_w[1], exp_w[1]);
            end
            if (t < 24) begin
                n_checks++;
                if (busy_w[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_busy t=%0d got=%b exp=1", t, busy_w[1]);
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (dv_w[1][c]) begin
                    n_checks++;
                    if (qt.size() == 0) begin
                        n_fail++;
                        $display("FAIL b2b_return t=%0d got ch=%0d exp none", t, c);
                    end else begin
                        if (t - qt[0] != 3 || qc[0] != c || dout_w[1] !== word(qa[0])) begin
                            n_fail++;
                            $display("FAIL b2b_return got lag=%0d ch=%0d dout=%h exp lag=3 ch=%0d dout=%h",
                                     t - qt[0], c, dout_w[1], qc[0], word(qa[0]));
                        end
                        void'(qt.pop_front());
                        void'(qc.pop_front());
                        void'(qa.pop_front());
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (ack_w[1][c]) begin
                    qt.push_back(t);
                    qc.push_back(c);
                    qa.push_back(addr_s[1][c]);
                    addr_s[1][c] = 12'($urandom);
                end
            end
        end
        req_s[1] = '0;
        n_checks++;
        if (qt.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_missing got=%0d pending exp=0", qt.size());
        end
    endtask

    task automatic test_reset_mid();
        addr_s[1][1] = 12'h3C3;
        req_s[1] = 4'b0010;
        cen_s[1] = 1'b1;
        tick();
        cen_s[1] = 1'b0;
        req_s[1] = '0;
        n_checks++;
        if (ack_w[1] !== 4'b0010) begin
            n_fail++;
            $display("FAIL rmid_ack got=%b exp=0010", ack_w[1]);
        end
        rst_s[1] = 1'b1;
        tick();
        rst_s[1] = 1'b0;
        n_checks++;
        if (slot_w[1] !== 2'd0 || busy_w[1] !== 1'b0 || ra_w[1] !== 12'h0) begin
            n_fail++;
            $display("FAIL rmid_state got slot=%0d busy=%b ra=%h exp slot=0 busy=0 ra=000",
                     slot_w[1], busy_w[1], ra_w[1]);
        end
        for (int t = 0; t < 6; t++) begin
            n_checks++;
            if (dv_w[1] !== 4'h0 || obs_w[1] !== exp_w[1]) begin
                n_fail++;
                $display("FAIL rmid_dvalid t=%0d got=%h exp=%h", t, obs_w[1], exp_w[1]);
            end
            tick();
        end
    endtask

    task automatic test_withdraw();
        logic [11:0] ra0;
        logic        step_cen [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        step_req [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int          n = 0;
        req_s[0] = '0;
        while (slot_w[0] !== 2'd3 && n < 8) begin
            cen_s[0] = 1'b1;
            tick();
            n++;
        end
        cen_s[0] = 1'b0;
        n_checks++;
        if (slot_w[0] !== 2'd3) begin
            n_fail++;
            $display("FAIL wd_reach got slot=%0d exp 3", slot_w[0]);
        end
        tick();
        ra0 = ra_w[0];
        addr_s[0][0] = ~ra0;
        for (int s = 0; s < 6; s++) begin
            cen_s[0] = step_cen[s];
            req_s[0] = {3'b000, step_req[s]};
            tick();
            n_checks++;
            if (ack_w[0][0] !== 1'b0 || dv_w[0][0] !== 1'b0 || ra_w[0] !== ra0 ||
                obs_w[0] !== exp_w[0]) begin
                n_fail++;
                $display("FAIL withdraw step=%0d got ack=%b dv=%b ra=%h exp ack=0 dv=0 ra=%h",
                         s, ack_w[0][0], dv_w[0][0], ra_w[0], ra0);
            end
        end
        cen_s[0] = 1'b0;
        req_s[0] = '0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < NI; k++) begin
                rst_s[k] = ($urandom_range(63) == 0);
                cen_s[k] = ($urandom_range(2) != 0);
                req_s[k] = 4'($urandom);
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(3) == 0) addr_s[k][c] = 12'($urandom);
                end
            end
            tick();
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (obs_w[k] !== exp_w[k] || (ack_w[k] & (ack_w[k] - 4'd1)) != 4'h0 ||
                    (dv_w[k] & (dv_w[k] - 4'd1)) != 4'h0) begin
                    n_fail++;
                    $display("FAIL rand_model inst=%0d t=%0d got=%h exp=%h",
                             k, t, obs_w[k], exp_w[k]);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            rst_s[k] = 1'b0;
            cen_s[k] = 1'b0;
            req_s[k] = '0;
        end
        for (int t = 0; t < 5; t++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (obs_w[k] !== exp_w[k]) begin
                    n_fail++;
                    $display("FAIL rand_drain inst=%0d got=%h exp=%h", k, obs_w[k], exp_w[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_s[k] = 1'b1;
            cen_s[k] = 1'b0;
            req_s[k] = '0;
            for (int c = 0; c < 4; c++) addr_s[k][c] = '0;
        end
        test_reset();
        test_round_robin();
        test_only_ch2();
        test_free_slot();
        test_back_to_back();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
